// File: rtl/lutram_pkg.sv
// lutram_pkg: state encoding and shared constants for the lutram access front-end
package lutram_pkg;
   typedef enum logic {IDLE, FLUSH} state_t;
   localparam int DEFAULT_ENTRY_WIDTH = 64;
   localparam int RESP_QUEUE_DEPTH = 2;
endpackage

// File: rtl/lutram_response_queue.sv
// lutram_response_queue: 2-entry valid/ready FIFO holding {id, data} read responses
module lutram_response_queue
   import lutram_pkg::*;
#(
   parameter int WIDTH = DEFAULT_ENTRY_WIDTH
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             push_in,
   input  logic [WIDTH-1:0] push_data_in,
   input  logic             pop_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       count_out
);
   logic [WIDTH-1:0] mem [RESP_QUEUE_DEPTH];
   logic             wr_ptr, rd_ptr, pop;
   logic [1:0]       count;
   assign pop = pop_in && count != 2'd0;
   assign valid_out = count != 2'd0;
   assign data_out = mem[rd_ptr];
   assign count_out = count;
   always_ff @(posedge clk_in)
      if (push_in) mem[wr_ptr] <= push_data_in;
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push_in) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {1'b0, push_in} - {1'b0, pop};
      end
   end
   always_ff @(posedge clk_in)
      if (!reset_in) assert (!(push_in && count == 2'd2));
endmodule

// File: rtl/lutram_access_ctrl.sv
// lutram_access_ctrl: request front-end driving single_port_lutram with read queue and flush sweep
module lutram_access_ctrl
   import lutram_pkg::*;
#(
   parameter int SINGLE_ENTRY_SIZE_IN_BITS = DEFAULT_ENTRY_WIDTH,
   parameter int NUM_SET = 64,
   parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET),
   parameter int ID_WIDTH_IN_BITS = 4
) (
   input  logic                                 clk_in,
   input  logic                                 reset_in,
   input  logic                                 request_valid_in,
   output logic                                 request_ready_out,
   input  logic                                 request_write_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
   input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
   input  logic [ID_WIDTH_IN_BITS-1:0]          request_id_in,
   output logic                                 response_valid_out,
   input  logic                                 response_ready_in,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out,
   output logic [ID_WIDTH_IN_BITS-1:0]          response_id_out,
   input  logic                                 flush_in,
   output logic                                 flush_busy_out,
   output logic                                 flush_done_out,
   output logic                                 lutram_access_en_out,
   output logic                                 lutram_write_en_out,
   output logic [SET_PTR_WIDTH_IN_BITS-1:0]     lutram_set_addr_out,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] lutram_write_entry_out,
   input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] lutram_read_entry_in
);
   localparam int QW = ID_WIDTH_IN_BITS + SINGLE_ENTRY_SIZE_IN_BITS;
   state_t                         state;
   logic                           inflight, flush_done, idle, flushing, accept, pop, credit, q_valid;
   logic [ID_WIDTH_IN_BITS-1:0]    inflight_id;
   logic [SET_PTR_WIDTH_IN_BITS-1:0] flush_ctr;
   logic [1:0]                     q_count;
   logic [QW-1:0]                  q_data;
   assign idle = !reset_in && state == IDLE;
   assign flushing = !reset_in && state == FLUSH;
   assign pop = response_valid_out && response_ready_in;
   // a pop this cycle frees a slot, which keeps back-to-back reads at full rate
   assign credit = ({1'b0, q_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
   assign request_ready_out = idle && !flush_in && (request_write_in || credit);
   assign accept = request_valid_in && request_ready_out;
   assign lutram_access_en_out = accept || flushing;
   assign lutram_write_en_out = flushing || (accept && request_write_in);
   assign lutram_set_addr_out = flushing ? flush_ctr : accept ? request_addr_in : '0;
   assign lutram_write_entry_out = accept ? request_data_in : '0;
   assign flush_busy_out = flushing;
   assign flush_done_out = flush_done && !reset_in;
   assign response_valid_out = q_valid && !reset_in;
   assign response_data_out = reset_in ? '0 : q_data[SINGLE_ENTRY_SIZE_IN_BITS-1:0];
   assign response_id_out = reset_in ? '0 : q_data[QW-1:SINGLE_ENTRY_SIZE_IN_BITS];
   lutram_response_queue #(.WIDTH(QW)) u_queue (
      .clk_in(clk_in),
      .reset_in(reset_in),
      .push_in(inflight),
      .push_data_in({inflight_id, lutram_read_entry_in}),
      .pop_in(pop),
      .valid_out(q_valid),
      .data_out(q_data),
      .count_out(q_count)
   );
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state <= IDLE;
         inflight <= 1'b0;
         inflight_id <= '0;
         flush_ctr <= '0;
         flush_done <= 1'b0;
      end else begin
         inflight <= accept && !request_write_in;
         if (accept && !request_write_in) inflight_id <= request_id_in;
         flush_done <= 1'b0;
         if (state == IDLE) begin
            if (flush_in) begin
               state <= FLUSH;
               flush_ctr <= '0;
            end
         end else begin
            flush_ctr <= flush_ctr + 1'b1;
            if (flush_ctr == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1)) begin
               state <= IDLE;
               flush_done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_lutram_access_ctrl.sv
// tb_lutram_access_ctrl: directed bench with a behavioural single-port lutram
module tb_lutram_access_ctrl;
   localparam int W = 64, N = 64, A = 6, I = 4;
   logic clk_in = 1'b0, reset_in = 1'b1;
   logic request_valid_in = 1'b0, request_write_in = 1'b0, response_ready_in = 1'b1, flush_in = 1'b0;
   logic [A-1:0] request_addr_in = '0;
   logic [W-1:0] request_data_in = '0;
   logic [I-1:0] request_id_in = '0;
   logic request_ready_out, response_valid_out, flush_busy_out, flush_done_out;
   logic lutram_access_en_out, lutram_write_en_out;
   logic [A-1:0] lutram_set_addr_out;
   logic [W-1:0] lutram_write_entry_out, response_data_out;
   logic [W-1:0] lutram_read_entry_in = '0;
   logic [I-1:0] response_id_out;
   logic [W-1:0] mem [N];
   int checks = 0, errors = 0;
   always #5 clk_in = ~clk_in;
   lutram_access_ctrl #(.SINGLE_ENTRY_SIZE_IN_BITS(W), .NUM_SET(N), .SET_PTR_WIDTH_IN_BITS(A), .ID_WIDTH_IN_BITS(I)) dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .request_valid_in(request_valid_in), .request_ready_out(request_ready_out),
      .request_write_in(request_write_in), .request_addr_in(request_addr_in),
      .request_data_in(request_data_in), .request_id_in(request_id_in),
      .response_valid_out(response_valid_out), .response_ready_in(response_ready_in),
      .response_data_out(response_data_out), .response_id_out(response_id_out),
      .flush_in(flush_in), .flush_busy_out(flush_busy_out), .flush_done_out(flush_done_out),
      .lutram_access_en_out(lutram_access_en_out), .lutram_write_en_out(lutram_write_en_out),
      .lutram_set_addr_out(lutram_set_addr_out), .lutram_write_entry_out(lutram_write_entry_out),
      .lutram_read_entry_in(lutram_read_entry_in)
   );
   // sequential lutram: read data only updates on read accesses
   always @(posedge clk_in) begin
      if (reset_in) begin
         for (int i = 0; i < N; i++) mem[i] <= 64'hdead_0000 + W'(i);
      end else if (lutram_access_en_out) begin
         if (lutram_write_en_out) mem[lutram_set_addr_out] <= lutram_write_entry_out;
         else lutram_read_entry_in <= mem[lutram_set_addr_out];
      end
   end
   task automatic drive(input logic v, input logic w, input logic [A-1:0] a, input logic [W-1:0] d, input logic [I-1:0] id);
      request_valid_in = v; request_write_in = w; request_addr_in = a; request_data_in = d; request_id_in = id;
   endtask
   task automatic test_reset();
      drive(1, 1, 6'd9, 64'h55, 4'd1); flush_in = 1;
      repeat (2) @(negedge clk_in);
      #1;
      checks++; if (request_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", request_ready_out); end
      checks++; if (lutram_access_en_out !== 1'b0) begin errors++; $display("FAIL reset_access_en: got %b expected 0", lutram_access_en_out); end
      checks++; if (lutram_write_en_out !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b expected 0", lutram_write_en_out); end
      checks++; if (flush_busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", flush_busy_out); end
      checks++; if (response_valid_out !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", response_valid_out); end
      @(negedge clk_in);
      reset_in = 0; flush_in = 0; drive(0, 0, 0, 0, 0);
   endtask
   task automatic test_write_read();
      @(negedge clk_in); drive(1, 1, 6'd3, 64'hA5A5, 0); #1;
      checks++; if (request_ready_out !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", request_ready_out); end
      checks++; if ({lutram_access_en_out, lutram_write_en_out} !== 2'b11) begin errors++; $display("FAIL wr_strobes: got %b expected 11", {lutram_access_en_out, lutram_write_en_out}); end
      checks++; if (lutram_set_addr_out !== 6'd3) begin errors++; $display("FAIL wr_addr: got %0d expected 3", lutram_set_addr_out); end
      checks++; if (lutram_write_entry_out !== 64'hA5A5) begin errors++; $display("FAIL wr_data: got %h expected a5a5", lutram_write_entry_out); end
      @(negedge clk_in); drive(1, 0, 6'd3, 0, 4'd7); #1;
      checks++; if ({request_ready_out, lutram_access_en_out, lutram_write_en_out} !== 3'b110) begin errors++; $display("FAIL rd_accept: got %b expected 110", {request_ready_out, lutram_access_en_out, lutram_write_en_out}); end
      @(negedge clk_in); drive(0, 0, 0, 0, 0); #1;
      checks++; if (response_valid_out !== 1'b0) begin errors++; $display("FAIL rd_early: got %b expected 0", response_valid_out); end
      @(negedge clk_in); #1;
      checks++; if ({response_valid_out, response_id_out, response_data_out} !== {1'b1, 4'd7, 64'hA5A5}) begin errors++; $display("FAIL rd_resp: got v=%b id=%0d d=%h expected v=1 id=7 d=a5a5", response_valid_out, response_id_out, response_data_out); end
      @(negedge clk_in); #1;
      checks++; if (response_valid_out !== 1'b0) begin errors++; $display("FAIL rd_drained: got %b expected 0", response_valid_out); end
   endtask
   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin @(negedge clk_in); drive(1, 1, A'(i), 64'h100 + W'(i), 0); end
      for (int j = 0; j < 6; j++) begin
         @(negedge clk_in);
         if (j < 4) drive(1, 0, A'(j), 0, I'(j)); else drive(0, 0, 0, 0, 0);
         #1;
         if (j < 4) begin
            checks++; if (request_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", j, request_ready_out); end
         end
         if (j >= 2) begin
            checks++; if ({response_valid_out, response_id_out, response_data_out} !== {1'b1, I'(j - 2), 64'h100 + W'(j - 2)}) begin errors++; $display("FAIL b2b_resp%0d: got v=%b id=%0d d=%h expected id=%0d", j - 2, response_valid_out, response_id_out, response_data_out, j - 2); end
         end
      end
      @(negedge clk_in); #1;
      checks++; if (response_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", response_valid_out); end
   endtask
   task automatic test_backpressure();
      response_ready_in = 0;
      @(negedge clk_in); drive(1, 0, 6'd0, 0, 4'd1); #1;
      checks++; if (request_ready_out !== 1'b1) begin errors++; $display("FAIL bp_rd0_ready: got %b expected 1", request_ready_out); end
      @(negedge clk_in); drive(1, 0, 6'd1, 0, 4'd2); #1;
      checks++; if (request_ready_out !== 1'b1) begin errors++; $display("FAIL bp_rd1_ready: got %b expected 1", request_ready_out); end
      @(negedge clk_in); drive(1, 0, 6'd2, 0, 4'd3); #1;
      checks++; if ({request_ready_out, lutram_access_en_out} !== 2'b00) begin errors++; $display("FAIL bp_rd2_blocked: got %b expected 00", {request_ready_out, lutram_access_en_out}); end
      @(negedge clk_in); #1;
      checks++; if (request_ready_out !== 1'b0) begin errors++; $display("FAIL bp_rd3_blocked: got %b expected 0", request_ready_out); end
      drive(1, 1, 6'd10, 64'h77, 0); #1;
      checks++; if ({request_ready_out, lutram_access_en_out} !== 2'b11) begin errors++; $display("FAIL bp_write_ok: got %b expected 11", {request_ready_out, lutram_access_en_out}); end
      @(negedge clk_in); drive(0, 0, 0, 0, 0); response_ready_in = 1; #1;
      checks++; if ({response_valid_out, response_id_out, response_data_out} !== {1'b1, 4'd1, 64'h100}) begin errors++; $display("FAIL bp_resp0: got v=%b id=%0d d=%h expected id=1 d=100", response_valid_out, response_id_out, response_data_out); end
      @(negedge clk_in); #1;
      checks++; if ({response_valid_out, response_id_out, response_data_out} !== {1'b1, 4'd2, 64'h101}) begin errors++; $display("FAIL bp_resp1: got v=%b id=%0d d=%h expected id=2 d=101", response_valid_out, response_id_out, response_data_out); end
      @(negedge clk_in); drive(1, 0, 6'd10, 0, 4'd5); #1;
      checks++; if ({request_ready_out, response_valid_out} !== 2'b10) begin errors++; $display("FAIL bp_resume: got %b expected 10", {request_ready_out, response_valid_out}); end
      @(negedge clk_in); drive(0, 0, 0, 0, 0);
      @(negedge clk_in); #1;
      checks++; if ({response_valid_out, response_id_out, response_data_out} !== {1'b1, 4'd5, 64'h77}) begin errors++; $display("FAIL bp_raw: got v=%b id=%0d d=%h expected id=5 d=77", response_valid_out, response_id_out, response_data_out); end
   endtask
   task automatic test_flush();
      @(negedge clk_in); flush_in = 1; drive(1, 0, 6'd5, 0, 4'd9); #1;
      checks++; if ({request_ready_out, lutram_access_en_out} !== 2'b00) begin errors++; $display("FAIL fl_priority: got %b expected 00", {request_ready_out, lutram_access_en_out}); end
      for (int i = 0; i < N; i++) begin
         @(negedge clk_in); flush_in = (i == 10); #1;
         checks++; if ({flush_busy_out, request_ready_out, lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out, lutram_write_entry_out} !== {4'b1011, A'(i), 64'h0}) begin errors++; $display("FAIL fl_cycle%0d: got busy=%b rdy=%b en=%b we=%b addr=%0d d=%h", i, flush_busy_out, request_ready_out, lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out, lutram_write_entry_out); end
      end
      @(negedge clk_in); flush_in = 0; #1;
      checks++; if ({flush_busy_out, flush_done_out, request_ready_out} !== 3'b011) begin errors++; $display("FAIL fl_done: got busy/done/rdy=%b expected 011", {flush_busy_out, flush_done_out, request_ready_out}); end
      @(negedge clk_in); drive(0, 0, 0, 0, 0); #1;
      checks++; if (flush_done_out !== 1'b0) begin errors++; $display("FAIL fl_done_pulse: got %b expected 0", flush_done_out); end
      @(negedge clk_in); #1;
      checks++; if ({response_valid_out, response_id_out, response_data_out} !== {1'b1, 4'd9, 64'h0}) begin errors++; $display("FAIL fl_zero: got v=%b id=%0d d=%h expected id=9 d=0", response_valid_out, response_id_out, response_data_out); end
   endtask
   task automatic test_flush_inflight();
      int n = 0;
      @(negedge clk_in); drive(1, 1, 6'd4, 64'hBEEF, 0);
      @(negedge clk_in); drive(1, 0, 6'd4, 0, 4'd3);
      @(negedge clk_in); drive(0, 0, 0, 0, 0); flush_in = 1; #1;
      checks++; if (request_ready_out !== 1'b0) begin errors++; $display("FAIL fi_flush_ready: got %b expected 0", request_ready_out); end
      @(negedge clk_in); flush_in = 0; drive(1, 1, 6'd6, 64'h66, 0); #1;
      checks++; if ({flush_busy_out, response_valid_out, response_id_out, response_data_out} !== {2'b11, 4'd3, 64'hBEEF}) begin errors++; $display("FAIL fi_resp: got busy=%b v=%b id=%0d d=%h expected busy=1 id=3 d=beef", flush_busy_out, response_valid_out, response_id_out, response_data_out); end
      for (int k = 0; k < 100 && flush_busy_out; k++) begin
         n++;
         checks++; if (request_ready_out !== 1'b0) begin errors++; $display("FAIL fi_wait%0d: got %b expected 0", k, request_ready_out); end
         @(negedge clk_in); #1;
      end
      checks++; if (n !== N) begin errors++; $display("FAIL fi_flush_len: got %0d expected %0d", n, N); end
      checks++; if ({flush_done_out, request_ready_out} !== 2'b11) begin errors++; $display("FAIL fi_release: got done/rdy=%b expected 11", {flush_done_out, request_ready_out}); end
      @(negedge clk_in); drive(1, 0, 6'd6, 0, 4'd2);
      @(negedge clk_in); drive(0, 0, 0, 0, 0);
      @(negedge clk_in); #1;
      checks++; if ({response_valid_out, response_id_out, response_data_out} !== {1'b1, 4'd2, 64'h66}) begin errors++; $display("FAIL fi_late_write: got v=%b id=%0d d=%h expected id=2 d=66", response_valid_out, response_id_out, response_data_out); end
   endtask
   task automatic test_reset_mid_flush();
      logic seen = 1'b0;
      @(negedge clk_in); flush_in = 1;
      @(negedge clk_in); flush_in = 0;
      repeat (20) @(negedge clk_in);
      #1;
      checks++; if (lutram_set_addr_out !== 6'd20) begin errors++; $display("FAIL rm_addr: got %0d expected 20", lutram_set_addr_out); end
      reset_in = 1; #1;
      @(negedge clk_in); #1;
      checks++; if ({flush_busy_out, lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out, request_ready_out, flush_done_out} !== '0) begin errors++; $display("FAIL rm_outputs: got busy=%b en=%b we=%b addr=%0d rdy=%b done=%b expected all 0", flush_busy_out, lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out, request_ready_out, flush_done_out); end
      @(negedge clk_in); reset_in = 0; #1;
      checks++; if ({flush_busy_out, request_ready_out, response_valid_out} !== 3'b010) begin errors++; $display("FAIL rm_idle: got busy/rdy/valid=%b expected 010", {flush_busy_out, request_ready_out, response_valid_out}); end
      repeat (70) begin @(negedge clk_in); #1; if (flush_done_out) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_done: got %b expected 0", seen); end
   endtask
   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_flush_inflight();
      test_reset_mid_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
